// File: rtl/endian_swap_stream.sv
// -----------------------------------------------------------------------------
// endian_swap_stream
//
// Streaming byte-reorder stage. Each accepted beat is transformed by its own
// in_mode and registered. A one-entry skid register keeps full throughput
// while in_ready stays a registered signal.
//
// Modes: 00 pass, 01 full byte reverse, 10 swap bytes within each halfword,
//        11 reverse halfword order (bytes inside a halfword keep their order).
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   source beat valid
//   in_ready   stage can accept a beat (registered, equals !skid_valid)
//   in_data    source word, byte k = in_data[8k+7:8k]
//   in_mode    swap mode, sampled with the beat
//   out_valid  result valid
//   out_ready  sink accepts result
//   out_data   reordered word, stable while stalled
//   beat_cnt   count of output handshakes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module endian_swap_stream #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  beat_cnt
);

   localparam int unsigned NBytes = DATA_W / 8;
   localparam int unsigned NHalf  = DATA_W / 16;

   generate
      if ((DATA_W % 16) != 0 || DATA_W < 16) begin : g_bad_width
         $error("endian_swap_stream: DATA_W must be a multiple of 16 and >= 16");
      end
   endgenerate

   typedef enum logic [1:0] {
      StEmpty = 2'd0,  // output and skid registers empty
      StOne   = 2'd1,  // output register full, skid empty
      StFull  = 2'd2   // both full, input stalled
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   or_data_q, or_data_d;
   logic [DATA_W-1:0]   sk_data_q, sk_data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   xf_data;
   logic                accept;
   logic                xfer;

   // Byte reorder of the incoming word. The mode only affects the beat being
   // accepted, since the transformed value (not the mode) is what gets stored.
   always_comb begin
      xf_data = in_data;
      for (int k = 0; k < int'(NBytes); k++) begin
         case (in_mode)
            2'b01:   xf_data[8*k +: 8] = in_data[8*(int'(NBytes) - 1 - k) +: 8];
            2'b10:   xf_data[8*k +: 8] = in_data[8*(k ^ 1) +: 8];
            2'b11:   xf_data[8*k +: 8] = in_data[8*(2*(int'(NHalf) - 1 - k/2) + k%2) +: 8];
            default: xf_data[8*k +: 8] = in_data[8*k +: 8];
         endcase
      end
   end

   assign in_ready  = (state_q != StFull);
   assign out_valid = (state_q != StEmpty);
   assign out_data  = or_data_q;
   assign beat_cnt  = cnt_q;

   assign accept = in_valid & in_ready;
   assign xfer   = out_valid & out_ready;

   always_comb begin
      state_d   = state_q;
      or_data_d = or_data_q;
      sk_data_d = sk_data_q;
      cnt_d     = cnt_q + (xfer ? CNT_W'(1) : CNT_W'(0));

      case (state_q)
         StEmpty: begin
            if (accept) begin
               or_data_d = xf_data;
               state_d   = StOne;
            end
         end
         StOne: begin
            if (accept && xfer) begin
               or_data_d = xf_data;
            end else if (accept) begin
               // Sink stalled: park the new beat in the skid register.
               sk_data_d = xf_data;
               state_d   = StFull;
            end else if (xfer) begin
               state_d   = StEmpty;
            end
         end
         StFull: begin
            if (xfer) begin
               or_data_d = sk_data_q;
               state_d   = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StEmpty;
         or_data_q <= '0;
         sk_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         or_data_q <= or_data_d;
         sk_data_q <= sk_data_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_endian_swap_stream.sv
module tb_endian_swap_stream;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   // Main DUT: DATA_W=32, CNT_W=16
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [31:0] in_data = '0, out_data;
   logic [1:0]  in_mode = '0;
   logic [15:0] beat_cnt;

   // Wide DUT: DATA_W=64
   logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0;
   logic [63:0] w_in_data = '0, w_out_data;
   logic [1:0]  w_in_mode = '0;
   logic [15:0] w_beat_cnt;

   // Narrow-counter DUT: CNT_W=4
   logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
   logic [31:0] c_in_data = '0, c_out_data;
   logic [1:0]  c_in_mode = '0;
   logic [3:0]  c_beat_cnt;

   int total = 0;
   int bad = 0;

   endian_swap_stream #(.DATA_W(32), .CNT_W(16)) u_dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .beat_cnt(beat_cnt)
   );

   endian_swap_stream #(.DATA_W(64), .CNT_W(16)) u_dut_w (
      .clk(clk), .resetn(resetn), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_data(w_in_data), .in_mode(w_in_mode), .out_valid(w_out_valid),
      .out_ready(w_out_ready), .out_data(w_out_data), .beat_cnt(w_beat_cnt)
   );

   endian_swap_stream #(.DATA_W(32), .CNT_W(4)) u_dut_c (
      .clk(clk), .resetn(resetn), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_mode(c_in_mode), .out_valid(c_out_valid),
      .out_ready(c_out_ready), .out_data(c_out_data), .beat_cnt(c_beat_cnt)
   );

   // Reference transform for 32-bit words, written out explicitly per mode.
   function automatic logic [31:0] model32(input logic [31:0] d, input logic [1:0] m);
      case (m)
         2'b01:   return {d[7:0], d[15:8], d[23:16], d[31:24]};
         2'b10:   return {d[23:16], d[31:24], d[7:0], d[15:8]};
         2'b11:   return {d[15:0], d[31:16]};
         default: return d;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      in_valid = 1'b0;
      out_ready = 1'b0;
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      #12;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      total++;
      if (out_data !== 32'h0) begin
         bad++; $display("FAIL reset_out_data got=%h exp=0", out_data);
      end
      total++;
      if (beat_cnt !== 16'd0) begin
         bad++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt);
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_modes;
      logic [31:0] exp_v [4];
      exp_v[0] = 32'hAABBCCDD;
      exp_v[1] = 32'hDDCCBBAA;
      exp_v[2] = 32'hBBAADDCC;
      exp_v[3] = 32'hCCDDAABB;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = 32'hAABBCCDD;
         in_mode = 2'(i);
         tick();
         total++;
         if (out_valid !== 1'b1 || out_data !== exp_v[i]) begin
            bad++;
            $display("FAIL modes_%0d got valid=%b data=%h exp valid=1 data=%h",
                     i, out_valid, out_data, exp_v[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      total++;
      if (beat_cnt !== 16'd4 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL modes_cnt got cnt=%0d valid=%b exp cnt=4 valid=0", beat_cnt, out_valid);
      end
   endtask

   task automatic test_backpressure;
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h11223344; in_mode = 2'b01;
      tick();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h44332211) begin
         bad++;
         $display("FAIL bp_first got rdy=%b vld=%b data=%h exp rdy=1 vld=1 data=44332211",
                  in_ready, out_valid, out_data);
      end
      in_data = 32'h55667788; in_mode = 2'b00;
      tick();
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready);
      end
      in_data = 32'h99AABBCC; in_mode = 2'b11;
      tick();
      total++;
      if (in_ready !== 1'b0 || out_data !== 32'h44332211) begin
         bad++;
         $display("FAIL bp_hold got rdy=%b data=%h exp rdy=0 data=44332211", in_ready, out_data);
      end
      out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h55667788 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_drain1 got vld=%b data=%h rdy=%b exp vld=1 data=55667788 rdy=1",
                  out_valid, out_data, in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hBBCC99AA) begin
         bad++;
         $display("FAIL bp_drain2 got vld=%b data=%h exp vld=1 data=bbcc99aa", out_valid, out_data);
      end
      in_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0 || beat_cnt !== 16'd3 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_end got vld=%b cnt=%0d rdy=%b exp vld=0 cnt=3 rdy=1",
                  out_valid, beat_cnt, in_ready);
      end
   endtask

   task automatic test_random;
      logic [31:0] q [$];
      logic [31:0] exp_d;
      int sent = 0, got = 0, cyc = 0;
      bit pending = 0, acc, xf;
      do_reset();
      while (got < 1000 && cyc < 20000) begin
         if (!pending) begin
            in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            in_data  = $urandom;
            in_mode  = 2'($urandom_range(0, 3));
         end
         out_ready = ($urandom_range(0, 1) == 1);
         acc = in_valid && in_ready;
         xf  = out_valid && out_ready;
         if (xf) begin
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL rand_extra beat got data=%h exp none", out_data);
            end else begin
               exp_d = q.pop_front();
               if (out_data !== exp_d) begin
                  bad++; $display("FAIL rand_beat_%0d got=%h exp=%h", got, out_data, exp_d);
               end
            end
            got++;
         end
         if (acc) begin
            q.push_back(model32(in_data, in_mode));
            sent++;
         end
         pending = in_valid && !acc;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++;
      if (got < 1000) begin
         bad++; $display("FAIL rand_timeout got=%0d beats exp=1000", got);
      end
      total++;
      if (beat_cnt !== 16'd1000) begin
         bad++; $display("FAIL rand_cnt got=%0d exp=1000", beat_cnt);
      end
   endtask

   task automatic test_reset_full;
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h01020304; in_mode = 2'b00;
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h0A0B0C0D;
      tick();
      in_data = 32'h1A1B1C1D;
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || beat_cnt !== 16'd1) begin
         bad++;
         $display("FAIL rf_pre got vld=%b rdy=%b cnt=%0d exp vld=1 rdy=0 cnt=1",
                  out_valid, in_ready, beat_cnt);
      end
      #2;
      resetn = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || beat_cnt !== 16'd0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rf_async got vld=%b data=%h cnt=%0d rdy=%b exp vld=0 data=0 cnt=0 rdy=1",
                  out_valid, out_data, beat_cnt, in_ready);
      end
      resetn = 1'b1;
      in_valid = 1'b1; in_data = 32'hCAFEF00D; in_mode = 2'b01;
      out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h0DF0FECA) begin
         bad++;
         $display("FAIL rf_after got vld=%b data=%h exp vld=1 data=0df0feca", out_valid, out_data);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_wide;
      logic [63:0] exp_w [3];
      exp_w[0] = 64'h7766554433221100;
      exp_w[1] = 64'h1100332255447766;
      exp_w[2] = 64'h6677445522330011;
      do_reset();
      w_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w_in_valid = 1'b1;
         w_in_data = 64'h0011223344556677;
         w_in_mode = 2'(i + 1);
         tick();
         total++;
         if (w_out_valid !== 1'b1 || w_out_data !== exp_w[i]) begin
            bad++;
            $display("FAIL wide_mode%0d got vld=%b data=%h exp vld=1 data=%h",
                     i + 1, w_out_valid, w_out_data, exp_w[i]);
         end
      end
      w_in_valid = 1'b0;
      tick();
      total++;
      if (w_beat_cnt !== 16'd3) begin
         bad++; $display("FAIL wide_cnt got=%0d exp=3", w_beat_cnt);
      end
      w_out_ready = 1'b0;
   endtask

   task automatic test_cnt_wrap;
      do_reset();
      c_out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         c_in_valid = (i < 17);
         c_in_data = 32'(i);
         tick();
         if (i == 15) begin
            total++;
            if (c_beat_cnt !== 4'd15) begin
               bad++; $display("FAIL wrap_15 got=%0d exp=15", c_beat_cnt);
            end
         end
         if (i == 16) begin
            total++;
            if (c_beat_cnt !== 4'd0) begin
               bad++; $display("FAIL wrap_0 got=%0d exp=0", c_beat_cnt);
            end
         end
      end
      total++;
      if (c_beat_cnt !== 4'd1 || c_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL wrap_end got cnt=%0d vld=%b exp cnt=1 vld=0", c_beat_cnt, c_out_valid);
      end
      c_in_valid = 1'b0;
      c_out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_modes();
      test_backpressure();
      test_random();
      test_reset_full();
      test_wide();
      test_cnt_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
